// File: rtl/slc_datapath_param.sv
// Parametrised SLC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, CC/BEN,
// one-hot bus mux and a handshaked memory port with timeout.
module slc_datapath_param #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_reg,
  input  logic             ld_ben,
  input  logic             ld_cc,
  input  logic             ld_ir,
  input  logic             ld_pc,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic [3:0]       gate_sel,
  input  logic             drmux,
  input  logic             sr1mux,
  input  logic             addr1mux,
  input  logic [1:0]       addr2mux,
  input  logic [1:0]       pcmux,
  input  logic [1:0]       aluk,
  input  logic             mem_start,
  input  logic             mem_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err,
  output logic             bus_err,
  output logic             ben,
  output logic [2:0]       cc,
  output logic [15:0]      ir,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] mar,
  output logic [WIDTH-1:0] mdr
);

  localparam int unsigned NREGS = 8;
  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_e;

  mem_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] sr1_val;
  logic [WIDTH-1:0] sr2_val;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] addr2;
  logic [WIDTH-1:0] addr_sum;
  logic [WIDTH-1:0] pc_nxt;
  logic [2:0]       cc_nxt;
  logic [2:0]       dr_idx;
  logic [2:0]       sr1_idx;
  logic             gate_multi;
  logic             busy_now;
  logic             start_acc;
  logic             ack_read;

  // Register file selects and combinational reads
  always_comb begin
    dr_idx  = drmux ? 3'd7 : ir[11:9];
    sr1_idx = sr1mux ? ir[11:9] : ir[8:6];
    sr1_val = regs[sr1_idx];
    sr2_val = regs[ir[2:0]];
  end

  // ALU; immediate mode substitutes SEXT(ir[4:0]) for SR2
  always_comb begin
    alu_b   = ir[5] ? {{(WIDTH-5){ir[4]}}, ir[4:0]} : sr2_val;
    alu_out = '0;
    case (aluk)
      2'd0:    alu_out = sr1_val + alu_b;
      2'd1:    alu_out = sr1_val & alu_b;
      2'd2:    alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  // Address adder feeding both MARMUX and PCMUX
  always_comb begin
    addr1 = addr1mux ? sr1_val : pc;
    addr2 = '0;
    case (addr2mux)
      2'd0:    addr2 = '0;
      2'd1:    addr2 = {{(WIDTH-6){ir[5]}}, ir[5:0]};
      2'd2:    addr2 = {{(WIDTH-9){ir[8]}}, ir[8:0]};
      default: addr2 = {{(WIDTH-11){ir[10]}}, ir[10:0]};
    endcase
    addr_sum = addr1 + addr2;
  end

  always_comb begin
    pc_nxt = pc;
    case (pcmux)
      2'd0:    pc_nxt = pc + WIDTH'(1);
      2'd1:    pc_nxt = bus;
      2'd2:    pc_nxt = addr_sum;
      default: pc_nxt = pc;
    endcase
  end

  // Bus: a multi-hot select drives nothing rather than a wired-OR of drivers
  always_comb begin
    gate_multi = (gate_sel & (gate_sel - 4'd1)) != 4'd0;
    bus        = '0;
    case (gate_sel)
      4'b1000: bus = mdr;
      4'b0100: bus = alu_out;
      4'b0010: bus = pc;
      4'b0001: bus = addr_sum;
      default: bus = '0;
    endcase
  end

  always_comb begin
    if (bus[WIDTH-1])        cc_nxt = 3'b100;
    else if (bus == '0)      cc_nxt = 3'b010;
    else                     cc_nxt = 3'b001;
  end

  // Memory access FSM next-state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_now  = (state == ST_REQ);
    start_acc = 1'b0;
    ack_read  = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (mem_start) begin
          start_acc = 1'b1;
          state_nxt = ST_REQ;
          cnt_nxt   = '0;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          ack_read  = ~mem_we;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = ST_ERR;
          cnt_nxt   = CNT_W'(MEM_TIMEOUT);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Memory port outputs, all registered off the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_busy  <= 1'b0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req  <= (state_nxt == ST_REQ);
      mem_busy <= (state_nxt == ST_REQ);
      mem_done <= (state == ST_REQ) && mem_ack;
      if (start_acc) begin
        mem_addr  <= mar;
        mem_wdata <= mdr;
        mem_we    <= mem_write;
        mem_err   <= 1'b0;
      end else if ((state == ST_REQ) && (state_nxt == ST_ERR)) begin
        mem_err <= 1'b1;
      end
    end
  end

  // Architectural registers; read data wins over ld_mdr on the ack edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mar     <= '0;
      mdr     <= '0;
      cc      <= 3'b010;
      ben     <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (ld_pc) pc <= pc_nxt;
      if (ld_ir) ir <= bus[15:0];
      if (ld_mar && !busy_now) mar <= bus;
      if (ack_read) mdr <= mem_rdata;
      else if (ld_mdr && !busy_now) mdr <= bus;
      if (ld_cc) cc <= cc_nxt;
      if (ld_ben) ben <= |(ir[11:9] & cc);
      if (gate_multi) bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (ld_reg) begin
      regs[dr_idx] <= bus;
    end
  end

endmodule

// File: tb/tb_slc_datapath_param.sv
// Directed bench for slc_datapath_param: reset, ALU/CC, PC/MARMUX, memory read/write,
// timeout, BEN and bus error.
module tb_slc_datapath_param;

  localparam int unsigned      WIDTH       = 16;
  localparam logic [WIDTH-1:0] RESET_PC    = 16'h3000;
  localparam int unsigned      MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  logic ld_reg, ld_ben, ld_cc, ld_ir, ld_pc, ld_mar, ld_mdr;
  logic [3:0] gate_sel;
  logic drmux, sr1mux, addr1mux;
  logic [1:0] addr2mux, pcmux, aluk;
  logic mem_start, mem_write;
  logic mem_req, mem_we;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_ack, mem_busy, mem_done, mem_err, bus_err, ben;
  logic [2:0] cc;
  logic [15:0] ir;
  logic [WIDTH-1:0] pc, mar, mdr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slc_datapath_param #(
    .WIDTH(WIDTH), .RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_reg(ld_reg), .ld_ben(ld_ben), .ld_cc(ld_cc), .ld_ir(ld_ir),
    .ld_pc(ld_pc), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .gate_sel(gate_sel), .drmux(drmux), .sr1mux(sr1mux), .addr1mux(addr1mux),
    .addr2mux(addr2mux), .pcmux(pcmux), .aluk(aluk),
    .mem_start(mem_start), .mem_write(mem_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_busy(mem_busy),
    .mem_done(mem_done), .mem_err(mem_err), .bus_err(bus_err),
    .ben(ben), .cc(cc), .ir(ir), .pc(pc), .mar(mar), .mdr(mdr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    ld_reg = 0; ld_ben = 0; ld_cc = 0; ld_ir = 0; ld_pc = 0; ld_mar = 0; ld_mdr = 0;
    gate_sel = 4'b0000; drmux = 0; sr1mux = 0; addr1mux = 0;
    addr2mux = 2'd0; pcmux = 2'd3; aluk = 2'd0;
    mem_start = 0; mem_write = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  // Bring a constant into MDR through a one-wait-state memory read
  task automatic load_mdr(input logic [WIDTH-1:0] v);
    clear_ctrl();
    mem_start = 1; step();
    mem_start = 0; mem_ack = 1; mem_rdata = v; step();
    clear_ctrl();
  endtask

  task automatic set_ir(input logic [15:0] v);
    load_mdr(v);
    gate_sel = 4'b1000; ld_ir = 1; step();
    clear_ctrl();
  endtask

  task automatic set_reg(input logic [2:0] r, input logic [WIDTH-1:0] v);
    set_ir({4'h0, r, 9'h000});
    load_mdr(v);
    gate_sel = 4'b1000; ld_reg = 1; step();
    clear_ctrl();
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset = 1; step(); step();
    reset = 0;
    checks++; if (pc !== 16'h3000) begin errors++; $display("FAIL reset_pc: got %h expected 3000", pc); end
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL reset_cc: got %b expected 010", cc); end
    checks++; if (ben !== 1'b0) begin errors++; $display("FAIL reset_ben: got %b expected 0", ben); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    checks++; if ({ir, mar, mdr} !== 48'h0) begin errors++; $display("FAIL reset_regs: got ir=%h mar=%h mdr=%h expected 0", ir, mar, mdr); end
    checks++; if ({mem_busy, mem_done, mem_err} !== 3'b000) begin errors++; $display("FAIL reset_mem_flags: got %b expected 000", {mem_busy, mem_done, mem_err}); end
  endtask

  task automatic test_alu();
    set_reg(3'd2, 16'h0005);
    set_reg(3'd3, 16'hFFFE);
    set_ir(16'h1283);                       // ADD R1, R2, R3
    gate_sel = 4'b0100; aluk = 2'd0; ld_reg = 1; ld_cc = 1; step();
    clear_ctrl();
    checks++; if (cc !== 3'b001) begin errors++; $display("FAIL add_cc: got %b expected 001", cc); end
    sr1mux = 1; aluk = 2'd3; gate_sel = 4'b0100; ld_mar = 1; step();
    clear_ctrl();
    checks++; if (mar !== 16'h0003) begin errors++; $display("FAIL add_r1: got %h expected 0003", mar); end
    set_ir(16'h187C);                       // ADD R4, R1, #-4
    gate_sel = 4'b0100; aluk = 2'd0; ld_reg = 1; ld_cc = 1; step();
    clear_ctrl();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL addi_cc: got %b expected 100", cc); end
    sr1mux = 1; aluk = 2'd3; gate_sel = 4'b0100; ld_mar = 1; step();
    clear_ctrl();
    checks++; if (mar !== 16'hFFFF) begin errors++; $display("FAIL addi_r4: got %h expected FFFF", mar); end
    aluk = 2'd1; gate_sel = 4'b0100; ld_mar = 1; step();   // R1 AND #-4 = 3 & FFFC
    clear_ctrl();
    checks++; if (mar !== 16'h0000) begin errors++; $display("FAIL and_imm: got %h expected 0000", mar); end
  endtask

  task automatic test_pc_addr();
    pcmux = 2'd0; ld_pc = 1; step();
    clear_ctrl();
    checks++; if (pc !== 16'h3001) begin errors++; $display("FAIL pc_inc: got %h expected 3001", pc); end
    pcmux = 2'd2; addr1mux = 0; addr2mux = 2'd2; ld_pc = 1; step();
    clear_ctrl();
    checks++; if (pc !== 16'h307D) begin errors++; $display("FAIL pc_offset9: got %h expected 307D", pc); end
    addr1mux = 1; addr2mux = 2'd3; gate_sel = 4'b0001; ld_mar = 1; step();
    clear_ctrl();
    checks++; if (mar !== 16'h007F) begin errors++; $display("FAIL marmux_offset11: got %h expected 007F", mar); end
  endtask

  task automatic test_read();
    int busy_cycles;
    busy_cycles = 0;
    load_mdr(16'h0040);
    gate_sel = 4'b1000; ld_mar = 1; step();
    clear_ctrl();
    mem_start = 1; mem_write = 0; step();
    clear_ctrl();
    if (mem_busy) busy_cycles++;
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin errors++; $display("FAIL read_req: got req=%b we=%b addr=%h expected 1 0 0040", mem_req, mem_we, mem_addr); end
    gate_sel = 4'b0010; ld_mdr = 1; ld_mar = 1; step();
    clear_ctrl();
    if (mem_busy) busy_cycles++;
    checks++; if ({mar, mdr} !== {16'h0040, 16'h0040}) begin errors++; $display("FAIL busy_ignores_ld: got mar=%h mdr=%h expected 0040 0040", mar, mdr); end
    step();
    if (mem_busy) busy_cycles++;
    mem_ack = 1; mem_rdata = 16'hBEEF; step();
    clear_ctrl();
    if (mem_busy) busy_cycles++;
    checks++; if (mdr !== 16'hBEEF) begin errors++; $display("FAIL read_mdr: got %h expected BEEF", mdr); end
    checks++; if ({mem_req, mem_done} !== 2'b01) begin errors++; $display("FAIL read_done: got req=%b done=%b expected 0 1", mem_req, mem_done); end
    step();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", mem_done); end
    checks++; if (busy_cycles != 3) begin errors++; $display("FAIL busy_len: got %0d expected 3", busy_cycles); end
  endtask

  task automatic test_write();
    mem_start = 1; mem_write = 1; step();
    clear_ctrl();
    checks++; if ({mem_req, mem_we, mem_wdata} !== {1'b1, 1'b1, 16'hBEEF}) begin errors++; $display("FAIL write_req: got req=%b we=%b wdata=%h expected 1 1 BEEF", mem_req, mem_we, mem_wdata); end
    mem_ack = 1; mem_rdata = 16'h0000; step();
    clear_ctrl();
    checks++; if ({mdr, mem_done} !== {16'hBEEF, 1'b1}) begin errors++; $display("FAIL write_ack: got mdr=%h done=%b expected BEEF 1", mdr, mem_done); end
  endtask

  task automatic test_timeout();
    int req_cycles;
    load_mdr(16'h1234);
    mem_start = 1; step();
    clear_ctrl();
    req_cycles = mem_req ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!mem_req) break;
      req_cycles++;
    end
    checks++; if (req_cycles != MEM_TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", req_cycles, MEM_TIMEOUT); end
    checks++; if ({mem_err, mem_busy, mdr} !== {1'b1, 1'b0, 16'h1234}) begin errors++; $display("FAIL timeout_state: got err=%b busy=%b mdr=%h expected 1 0 1234", mem_err, mem_busy, mdr); end
    mem_ack = 1; mem_rdata = 16'hDEAD; step();
    clear_ctrl();
    checks++; if ({mdr, mem_done, mem_err} !== {16'h1234, 1'b0, 1'b1}) begin errors++; $display("FAIL late_ack: got mdr=%h done=%b err=%b expected 1234 0 1", mdr, mem_done, mem_err); end
    mem_start = 1; step();
    clear_ctrl();
    checks++; if ({mem_err, mem_req} !== 2'b01) begin errors++; $display("FAIL restart_clears_err: got err=%b req=%b expected 0 1", mem_err, mem_req); end
    mem_ack = 1; mem_rdata = 16'h5555; step();
    clear_ctrl();
    checks++; if (mdr !== 16'h5555) begin errors++; $display("FAIL restart_read: got %h expected 5555", mdr); end
  endtask

  task automatic test_ben();
    set_ir(16'h0800);
    load_mdr(16'h8000);
    gate_sel = 4'b1000; ld_cc = 1; step();
    clear_ctrl();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL ben_cc_n: got %b expected 100", cc); end
    ld_ben = 1; step();
    clear_ctrl();
    checks++; if (ben !== 1'b1) begin errors++; $display("FAIL ben_n_taken: got %b expected 1", ben); end
    set_ir(16'h0400);
    load_mdr(16'h0000);
    gate_sel = 4'b1000; ld_cc = 1; ld_ben = 1; step();   // BEN sees the old N
    clear_ctrl();
    checks++; if ({ben, cc} !== {1'b0, 3'b010}) begin errors++; $display("FAIL ben_old_cc: got ben=%b cc=%b expected 0 010", ben, cc); end
    ld_ben = 1; step();
    clear_ctrl();
    checks++; if (ben !== 1'b1) begin errors++; $display("FAIL ben_z_taken: got %b expected 1", ben); end
  endtask

  task automatic test_bus_err();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_pre: got %b expected 0", bus_err); end
    gate_sel = 4'b0110; ld_mar = 1; step();
    clear_ctrl();
    checks++; if ({mar, bus_err} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL multi_hot: got mar=%h bus_err=%b expected 0000 1", mar, bus_err); end
    step(); step();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky: got %b expected 1", bus_err); end
    mem_start = 1; step();
    clear_ctrl();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b expected 1", mem_req); end
    reset = 1; step();
    reset = 0;
    checks++; if ({mem_req, mem_busy, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_mid_req: got req=%b busy=%b bus_err=%b expected 000", mem_req, mem_busy, bus_err); end
    checks++; if ({pc, mdr} !== {16'h3000, 16'h0000}) begin errors++; $display("FAIL reset_mid_regs: got pc=%h mdr=%h expected 3000 0000", pc, mdr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_ctrl();
    test_reset();
    test_alu();
    test_pc_addr();
    test_read();
    test_write();
    test_timeout();
    test_ben();
    test_bus_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
